// File: rtl/sys_bus_pkg.sv
// ---------------------------------------------------------------------------
// sys_bus_pkg
// Shared definitions for the system bus and its master arbiter:
//   - CTRL_W and the read/write control encodings (000 = no access)
//   - arbiter state enum {IDLE, ACCESS}
//   - arbitration mode selectors PRIO_FIXED / PRIO_RR
// ---------------------------------------------------------------------------
package sys_bus_pkg;

    localparam int CTRL_W = 3;

    // Read control encodings
    localparam logic [CTRL_W-1:0] RD_NONE = 3'b000;
    localparam logic [CTRL_W-1:0] RD_LB   = 3'b001;
    localparam logic [CTRL_W-1:0] RD_LH   = 3'b010;
    localparam logic [CTRL_W-1:0] RD_LW   = 3'b011;
    localparam logic [CTRL_W-1:0] RD_LD   = 3'b100;
    localparam logic [CTRL_W-1:0] RD_LBU  = 3'b101;
    localparam logic [CTRL_W-1:0] RD_LHU  = 3'b110;
    localparam logic [CTRL_W-1:0] RD_LWU  = 3'b111;

    // Write control encodings
    localparam logic [CTRL_W-1:0] WR_NONE = 3'b000;
    localparam logic [CTRL_W-1:0] WR_SB   = 3'b001;
    localparam logic [CTRL_W-1:0] WR_SH   = 3'b010;
    localparam logic [CTRL_W-1:0] WR_SW   = 3'b011;
    localparam logic [CTRL_W-1:0] WR_SD   = 3'b100;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

endpackage

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational N-way find-first-set. The search begins at index i_ptr+1
// (mod N) and wraps, so i_ptr marks the most recently served position.
// Driving i_ptr with N-1 gives plain fixed priority (index 0 first).
//   i_req   [N-1:0]          candidate requests
//   i_ptr   [$clog2(N)-1:0]  last served index
//   o_gnt   [N-1:0]          one-hot winner (all zero when none)
//   o_valid                  at least one request present
// ---------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic                 o_valid
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sys_bus_arbiter
// N-master arbiter for the shared system bus. One master at a time is
// granted; its control/address/write data are muxed onto the bus until the
// slave answers with bus_ready (read data returned with a one-cycle m_done)
// or until MAX_WAIT cycles pass (m_done with m_err, m_dout cleared).
// Ports (per-master vectors flattened, master i in slice i):
//   clk, rst                      clock, asynchronous active-high reset
//   m_req/m_rd_ctrl/m_wr_ctrl     master requests and access controls
//   m_addr/m_din                  master address and write data
//   m_gnt                         one-hot grant for the whole access
//   m_done/m_err/m_dout           completion pulse, timeout flag, read data
//   bus_rd_ctrl/bus_wr_ctrl       bus controls (zero while idle)
//   bus_addr/bus_din              bus address and write data
//   bus_dout/bus_ready            slave read data and completion
//   busy                          high while an access is in flight
// ---------------------------------------------------------------------------
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int PRIO_MODE   = 0,
    parameter int MAX_WAIT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [CTRL_W*NUM_MASTERS-1:0] m_rd_ctrl,
    input  logic [CTRL_W*NUM_MASTERS-1:0] m_wr_ctrl,
    input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
    input  logic [DATA_W*NUM_MASTERS-1:0] m_din,
    output logic [NUM_MASTERS-1:0]        m_gnt,
    output logic [NUM_MASTERS-1:0]        m_done,
    output logic                          m_err,
    output logic [DATA_W-1:0]             m_dout,
    output logic [CTRL_W-1:0]             bus_rd_ctrl,
    output logic [CTRL_W-1:0]             bus_wr_ctrl,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [DATA_W-1:0]             bus_din,
    input  logic [DATA_W-1:0]             bus_dout,
    input  logic                          bus_ready,
    output logic                          busy
);

    localparam int PW    = $clog2(NUM_MASTERS);
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PW-1:0]    PTR_LAST = PW'(NUM_MASTERS - 1);

    arb_state_t              r_state, w_state_next;
    logic [NUM_MASTERS-1:0]  r_gnt, w_gnt_next;
    logic [NUM_MASTERS-1:0]  r_done, w_done_next;
    logic                    r_err, w_err_next;
    logic [DATA_W-1:0]       r_dout, w_dout_next;
    logic [CNT_W-1:0]        r_cnt, w_cnt_next;
    logic [PW-1:0]           r_last_gnt, w_last_next;

    logic [NUM_MASTERS-1:0]  w_elig;
    logic [PW-1:0]           w_ptr;
    logic [NUM_MASTERS-1:0]  w_pick_gnt;
    logic                    w_pick_valid;
    logic [PW-1:0]           w_pick_idx;

    // A master whose m_done is high this cycle still shows its request;
    // masking it here keeps the just-served access from being re-granted.
    assign w_elig = m_req & ~r_done;
    assign w_ptr  = (PRIO_MODE == PRIO_RR) ? r_last_gnt : PTR_LAST;

    rr_priority_picker #(
        .N(NUM_MASTERS)
    ) u_picker (
        .i_req   (w_elig),
        .i_ptr   (w_ptr),
        .o_gnt   (w_pick_gnt),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_pick_gnt[i]) begin
                w_pick_idx = PW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_dout     <= '0;
            r_cnt      <= '0;
            r_last_gnt <= PTR_LAST;
        end else begin
            r_state    <= w_state_next;
            r_gnt      <= w_gnt_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_dout     <= w_dout_next;
            r_cnt      <= w_cnt_next;
            r_last_gnt <= w_last_next;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_done_next  = '0;
        w_err_next   = 1'b0;
        w_dout_next  = r_dout;
        w_cnt_next   = r_cnt;
        w_last_next  = r_last_gnt;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_next   = w_pick_gnt;
                    w_cnt_next   = '0;
                    w_last_next  = w_pick_idx;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                // bus_ready takes precedence over a timeout in the same cycle
                if (bus_ready) begin
                    w_dout_next  = bus_dout;
                    w_done_next  = r_gnt;
                    w_gnt_next   = '0;
                    w_state_next = IDLE;
                end else if ((MAX_WAIT > 0) && (r_cnt == CNT_LAST)) begin
                    w_dout_next  = '0;
                    w_done_next  = r_gnt;
                    w_err_next   = 1'b1;
                    w_gnt_next   = '0;
                    w_state_next = IDLE;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Bus mux: mask each master's slice with its grant bit, then OR together.
    logic [CTRL_W-1:0] w_rd_sel   [NUM_MASTERS];
    logic [CTRL_W-1:0] w_wr_sel   [NUM_MASTERS];
    logic [ADDR_W-1:0] w_addr_sel [NUM_MASTERS];
    logic [DATA_W-1:0] w_din_sel  [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mux
        assign w_rd_sel[gi]   = r_gnt[gi] ? m_rd_ctrl[gi*CTRL_W +: CTRL_W] : '0;
        assign w_wr_sel[gi]   = r_gnt[gi] ? m_wr_ctrl[gi*CTRL_W +: CTRL_W] : '0;
        assign w_addr_sel[gi] = r_gnt[gi] ? m_addr[gi*ADDR_W +: ADDR_W]    : '0;
        assign w_din_sel[gi]  = r_gnt[gi] ? m_din[gi*DATA_W +: DATA_W]     : '0;
    end

    always_comb begin
        bus_rd_ctrl = '0;
        bus_wr_ctrl = '0;
        bus_addr    = '0;
        bus_din     = '0;
        if (r_state == ACCESS) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                bus_rd_ctrl = bus_rd_ctrl | w_rd_sel[i];
                bus_wr_ctrl = bus_wr_ctrl | w_wr_sel[i];
                bus_addr    = bus_addr    | w_addr_sel[i];
                bus_din     = bus_din     | w_din_sel[i];
            end
        end
    end

    assign m_gnt  = r_gnt;
    assign m_done = r_done;
    assign m_err  = r_err;
    assign m_dout = r_dout;
    assign busy   = (r_state == ACCESS);

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sys_bus_arbiter
// Directed bench with two arbiter instances sharing one clock:
//   u_fix: 2 masters, fixed priority, MAX_WAIT=4, 64-bit bus
//   u_rr : 3 masters, round-robin,    MAX_WAIT=4, 16-bit bus
// ---------------------------------------------------------------------------
module tb_sys_bus_arbiter;
    import sys_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- fixed-priority instance ----------------
    logic         f_rst;
    logic [1:0]   f_req;
    logic [5:0]   f_rd, f_wr;
    logic [127:0] f_addr, f_din;
    logic [1:0]   f_gnt, f_done;
    logic         f_err, f_busy, f_ready;
    logic [63:0]  f_dout, f_baddr, f_bdin, f_bdout;
    logic [2:0]   f_brd, f_bwr;

    sys_bus_arbiter #(
        .NUM_MASTERS(2), .ADDR_W(64), .DATA_W(64), .PRIO_MODE(PRIO_FIXED), .MAX_WAIT(4)
    ) u_fix (
        .clk(clk), .rst(f_rst), .m_req(f_req), .m_rd_ctrl(f_rd), .m_wr_ctrl(f_wr),
        .m_addr(f_addr), .m_din(f_din), .m_gnt(f_gnt), .m_done(f_done), .m_err(f_err),
        .m_dout(f_dout), .bus_rd_ctrl(f_brd), .bus_wr_ctrl(f_bwr), .bus_addr(f_baddr),
        .bus_din(f_bdin), .bus_dout(f_bdout), .bus_ready(f_ready), .busy(f_busy)
    );

    // ---------------- round-robin instance ----------------
    logic         r_rst;
    logic [2:0]   r_req;
    logic [8:0]   r_rd, r_wr;
    logic [47:0]  r_addr, r_din;
    logic [2:0]   r_gnt, r_done;
    logic         r_err, r_busy, r_ready;
    logic [15:0]  r_dout, r_baddr, r_bdin, r_bdout;
    logic [2:0]   r_brd, r_bwr;

    sys_bus_arbiter #(
        .NUM_MASTERS(3), .ADDR_W(16), .DATA_W(16), .PRIO_MODE(PRIO_RR), .MAX_WAIT(4)
    ) u_rr (
        .clk(clk), .rst(r_rst), .m_req(r_req), .m_rd_ctrl(r_rd), .m_wr_ctrl(r_wr),
        .m_addr(r_addr), .m_din(r_din), .m_gnt(r_gnt), .m_done(r_done), .m_err(r_err),
        .m_dout(r_dout), .bus_rd_ctrl(r_brd), .bus_wr_ctrl(r_bwr), .bus_addr(r_baddr),
        .bus_din(r_bdin), .bus_dout(r_bdout), .bus_ready(r_ready), .busy(r_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  rr_exp_gnt  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [15:0] rr_exp_addr [6] = '{16'h0010, 16'h0020, 16'h0030, 16'h0010, 16'h0020, 16'h0030};
    int busy_cycles;

    initial begin
        f_rst = 1'b1; f_req = '0; f_rd = '0; f_wr = '0; f_addr = '0; f_din = '0;
        f_bdout = '0; f_ready = 1'b0;
        r_rst = 1'b1; r_req = '0; r_rd = '0; r_wr = '0; r_addr = '0; r_din = '0;
        r_bdout = '0; r_ready = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        chk("rst_gnt",   f_gnt,   2'b00);
        chk("rst_done",  f_done,  2'b00);
        chk("rst_err",   f_err,   1'b0);
        chk("rst_dout",  f_dout,  64'h0);
        chk("rst_busy",  f_busy,  1'b0);
        chk("rst_baddr", f_baddr, 64'h0);
        chk("rst_rr_gnt", r_gnt,  3'b000);
        f_rst = 1'b0;
        r_rst = 1'b0;
        tick();

        // ---------------- fixed priority, both requesting ----------------
        f_rd    = {3'b010, 3'b001};
        f_addr  = {64'h200, 64'h100};
        f_bdout = 64'h11;
        f_ready = 1'b1;
        f_req   = 2'b11;
        tick();
        chk("fp_gnt0",  f_gnt,   2'b01);
        chk("fp_addr0", f_baddr, 64'h100);
        chk("fp_rd0",   f_brd,   3'b001);
        chk("fp_done_early", f_done, 2'b00);
        tick();
        chk("fp_done0", f_done, 2'b01);
        chk("fp_err0",  f_err,  1'b0);
        chk("fp_dout0", f_dout, 64'h11);
        chk("fp_gnt_clear0", f_gnt, 2'b00);
        $display("txn fixed m0 rd addr=0x100 dout=0x%0h", f_dout);
        f_req   = 2'b10;
        f_bdout = 64'h22;
        tick();
        chk("fp_gnt1",  f_gnt,   2'b10);
        chk("fp_addr1", f_baddr, 64'h200);
        tick();
        chk("fp_done1", f_done, 2'b10);
        chk("fp_dout1", f_dout, 64'h22);
        $display("txn fixed m1 rd addr=0x200 dout=0x%0h", f_dout);
        f_req = 2'b00; f_ready = 1'b0; f_rd = '0; f_addr = '0;
        tick();
        chk("fp_idle_busy",  f_busy,  1'b0);
        chk("fp_idle_baddr", f_baddr, 64'h0);

        // ---------------- wait states: ready at 4th ACCESS edge ----------------
        f_rd    = {3'b011, 3'b000};
        f_addr  = {64'h1000, 64'h0};
        f_bdout = 64'hDEADBEEF;
        f_req   = 2'b10;
        tick();
        busy_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            if (f_busy) busy_cycles++;
            if (c == 3) f_ready = 1'b1;
            tick();
        end
        chk("ws_busy_cycles", 64'(busy_cycles), 64'd4);
        chk("ws_done", f_done, 2'b10);
        chk("ws_err",  f_err,  1'b0);
        chk("ws_dout", f_dout, 64'hDEADBEEF);
        chk("ws_busy_after", f_busy, 1'b0);
        $display("txn fixed m1 rd addr=0x1000 waits=3 dout=0x%0h err=%0b", f_dout, f_err);
        f_req = 2'b00; f_ready = 1'b0; f_bdout = 64'h0BAD;
        tick();
        chk("ws_dout_hold",  f_dout, 64'hDEADBEEF);
        chk("ws_done_clear", f_done, 2'b00);

        // ---------------- timeout, bus_ready stuck low ----------------
        f_rd    = {3'b000, 3'b001};
        f_addr  = {64'h0, 64'h40};
        f_bdout = 64'h1234;
        f_req   = 2'b01;
        tick();
        chk("to_gnt", f_gnt, 2'b01);
        tick(); tick(); tick();
        chk("to_done_early", f_done, 2'b00);
        chk("to_busy_late",  f_busy, 1'b1);
        tick();
        chk("to_done", f_done, 2'b01);
        chk("to_err",  f_err,  1'b1);
        chk("to_dout", f_dout, 64'h0);
        chk("to_gnt_clear", f_gnt, 2'b00);
        chk("to_idle", f_busy, 1'b0);
        $display("txn fixed m0 rd addr=0x40 timeout err=%0b", f_err);
        f_req = 2'b00;
        tick();
        chk("to_err_clear", f_err, 1'b0);

        // ---------------- ready in the timeout cycle: ready wins ----------------
        f_req = 2'b01;
        tick();
        tick(); tick(); tick();
        f_ready = 1'b1;
        tick();
        chk("tb_done", f_done, 2'b01);
        chk("tb_err",  f_err,  1'b0);
        chk("tb_dout", f_dout, 64'h1234);
        $display("txn fixed m0 rd addr=0x40 waits=3 dout=0x%0h err=%0b", f_dout, f_err);
        f_req = 2'b00; f_ready = 1'b0;
        tick();

        // ---------------- asynchronous reset mid-access ----------------
        f_req = 2'b01;
        tick();
        chk("ra_gnt", f_gnt, 2'b01);
        tick();
        #2 f_rst = 1'b1;
        #1;
        chk("ra_gnt_zero",  f_gnt,   2'b00);
        chk("ra_busy_zero", f_busy,  1'b0);
        chk("ra_baddr",     f_baddr, 64'h0);
        chk("ra_brd",       f_brd,   3'b000);
        chk("ra_done",      f_done,  2'b00);
        tick();
        chk("ra_done_held", f_done, 2'b00);
        f_rst = 1'b0;
        tick();
        chk("ra_regrant", f_gnt, 2'b01);
        f_ready = 1'b1;
        tick();
        chk("ra_done_after", f_done, 2'b01);
        $display("txn fixed m0 rd addr=0x40 after reset dout=0x%0h", f_dout);
        f_req = 2'b00; f_ready = 1'b0;
        tick();

        // ---------------- write passthrough ----------------
        f_rd   = '0;
        f_wr   = {3'b000, 3'b011};
        f_addr = {64'h0, 64'h80};
        f_din  = {64'h0, 64'h55};
        f_req  = 2'b01;
        #1;
        chk("wp_idle_wr",   f_bwr,   3'b000);
        chk("wp_idle_addr", f_baddr, 64'h0);
        chk("wp_idle_din",  f_bdin,  64'h0);
        tick();
        chk("wp_wr",   f_bwr,   3'b011);
        chk("wp_addr", f_baddr, 64'h80);
        chk("wp_din",  f_bdin,  64'h55);
        chk("wp_rd",   f_brd,   3'b000);
        f_ready = 1'b1;
        tick();
        chk("wp_done",      f_done,  2'b01);
        chk("wp_post_wr",   f_bwr,   3'b000);
        chk("wp_post_addr", f_baddr, 64'h0);
        chk("wp_post_din",  f_bdin,  64'h0);
        $display("txn fixed m0 wr addr=0x80 din=0x55");
        f_req = 2'b00; f_ready = 1'b0;
        tick();

        // ---------------- round-robin, all three requesting ----------------
        r_rd    = {3'b001, 3'b001, 3'b001};
        r_addr  = {16'h0030, 16'h0020, 16'h0010};
        r_bdout = 16'h00A5;
        r_ready = 1'b1;
        r_req   = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr_gnt%0d", k),  r_gnt,   rr_exp_gnt[k]);
            chk($sformatf("rr_addr%0d", k), r_baddr, rr_exp_addr[k]);
            tick();
            chk($sformatf("rr_done%0d", k), r_done,  rr_exp_gnt[k]);
            $display("txn rr access %0d gnt=%b done=%b", k, rr_exp_gnt[k], r_done);
        end
        r_req = 3'b000; r_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the directed sequence completed");
        $fatal(1);
    end

endmodule
